// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit common-anode seven-segment scanner.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; codes above 9 show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // NOTE: seg gets a default before the loop so every path assigns it and no latch is inferred.
  always_comb begin
    seg = SEG_DASH;
    for (int i = 0; i < 10; i++) begin
      if (bcd == 4'(i)) seg = SEG_DIGIT[i];
    end
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed 4-digit scanner with per-slot anti-ghost guard, adjust-mode blink
// and once-per-frame shadow capture. Optional macro: LEADING_ZERO_BLANK_EN.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int GUARD     = 2,
  parameter int BLINK_DIV = 25000000,
  parameter int DP_POS    = 1
) (
  input  logic       clk_used,
  input  logic       rst,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] digit4,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [SCAN_W-1:0]  scan_cnt;
  digit_idx_t         idx;
  logic [3:0]         shadow [4];
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  logic       tick;
  logic       frame_end;
  logic       in_guard;
  logic [3:0] cur_digit;
  logic [6:0] dec_seg;
  logic       cur_blank;
  logic [3:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  assign tick      = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign frame_end = tick && (idx == 2'd3);
  assign in_guard  = (scan_cnt < SCAN_W'(GUARD));
  assign cur_digit = shadow[idx];

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_used) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (tick) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // NOTE: the shadow array is reset on purpose: the display must read 0000 before the first capture.
  always_ff @(posedge clk_used) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) shadow[i] <= 4'd0;
    end else if (frame_end) begin
      shadow[0] <= digit1;
      shadow[1] <= digit2;
      shadow[2] <= digit3;
      shadow[3] <= digit4;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] blank_mask;

  // Mask is frozen with the frame so a digit cannot flicker between blank and 0 mid-frame.
  always_ff @(posedge clk_used) begin
    if (rst) begin
      blank_mask <= 4'b0000;
    end else if (frame_end) begin
      blank_mask[0] <= (digit1 == 4'd0);
      blank_mask[1] <= (digit1 == 4'd0) && (digit2 == 4'd0);
      blank_mask[2] <= (digit1 == 4'd0) && (digit2 == 4'd0) && (digit3 == 4'd0);
      blank_mask[3] <= 1'b0;
    end
  end

  assign cur_blank = blank_mask[idx];
`else
  assign cur_blank = 1'b0;
`endif

  always_ff @(posedge clk_used) begin
    if (rst || !adj) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (!in_guard) begin
      an_d  = ~(4'b1000 >> idx);
      seg_d = cur_blank ? SEG_BLANK : dec_seg;
      dp_d  = (int'(idx) == DP_POS) ? 1'b0 : 1'b1;
      // idx[1] identifies the pair: 0 -> digit1/digit2, 1 -> digit3/digit4.
      if (adj && blink_phase && (idx[1] == sel)) an_d = AN_OFF;
    end
  end

  always_ff @(posedge clk_used) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: a cycle-level reference model pushes expected
// outputs into a queue and a negedge monitor pops and compares them.
module tb_seg7_scan_display;

  localparam int S  = 4;
  localparam int G  = 1;
  localparam int B  = 8;
  localparam int DP = 1;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } out_t;

  logic       clk_used = 1'b0;
  logic       rst, adj, sel;
  logic [3:0] d1, d2, d3, d4;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_tests = 0;
  int n_fail  = 0;

  out_t exp_q[$];

  // Reference model state: cycles since reset, consecutive adj cycles, captured frame.
  int         c_cnt;
  int         adj_run;
  logic [3:0] sh [4];
  logic [3:0] blank;

  always #5 clk_used = ~clk_used;

  seg7_scan_display #(
    .SCAN_DIV  (S),
    .GUARD     (G),
    .BLINK_DIV (B),
    .DP_POS    (DP)
  ) dut (
    .clk_used (clk_used),
    .rst      (rst),
    .digit1   (d1),
    .digit2   (d2),
    .digit3   (d3),
    .digit4   (d4),
    .adj      (adj),
    .sel      (sel),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  function automatic logic [6:0] digit_pattern(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Expected outputs after the coming edge, from the model state and current inputs.
  function automatic out_t model_out();
    out_t o;
    int   scan, slot;
    bit   phase;
    o.an  = 4'b1111;
    o.seg = 7'b1111111;
    o.dp  = 1'b1;
    if (rst) return o;
    scan = c_cnt % S;
    slot = (c_cnt / S) % 4;
    if (scan < G) return o;
    o.an = 4'b1111;
    o.an[3 - slot] = 1'b0;
    o.seg = blank[slot] ? 7'b1111111 : digit_pattern(sh[slot]);
    o.dp  = (slot == DP) ? 1'b0 : 1'b1;
    phase = ((adj_run / B) % 2) == 1;
    if (adj && phase && ((slot / 2) == int'(sel))) o.an = 4'b1111;
    return o;
  endfunction

  task automatic model_advance();
    if (rst) begin
      c_cnt   = 0;
      adj_run = 0;
      blank   = 4'b0000;
      for (int i = 0; i < 4; i++) sh[i] = 4'd0;
      return;
    end
    if ((c_cnt % S == S - 1) && ((c_cnt / S) % 4 == 3)) begin
      sh[0] = d1; sh[1] = d2; sh[2] = d3; sh[3] = d4;
      blank = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
      for (int i = 0; i < 3; i++) begin
        if (sh[i] != 4'd0) break;
        blank[i] = 1'b1;
      end
`endif
    end
    c_cnt   = c_cnt + 1;
    adj_run = adj ? adj_run + 1 : 0;
  endtask

  task automatic run(input int n);
    out_t e;
    for (int k = 0; k < n; k++) begin
      e = model_out();
      model_advance();
      @(posedge clk_used);
      exp_q.push_back(e);
      #1;
    end
  endtask

  task automatic check(input string name, input out_t act, input out_t expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s @%0t: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
               name, $time, act.an, act.seg, act.dp, expv.an, expv.seg, expv.dp);
    end
  endtask

  initial begin : monitor
    out_t e, a;
    forever begin
      @(negedge clk_used);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.an = an; a.seg = seg; a.dp = dp;
        check("scan_out", a, e);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int guard_cnt;
    rst = 1'b1; adj = 1'b0; sel = 1'b0;
    d1 = 4'd0; d2 = 4'd0; d3 = 4'd0; d4 = 4'd0;
    run(3);

    // First frame after release shows 0000, later frames show 1234.
    rst = 1'b0;
    d1 = 4'd1; d2 = 4'd2; d3 = 4'd3; d4 = 4'd4;
    run(40);

    // Change digit3 while slot 1 is being shown; the running frame must keep 3.
    guard_cnt = 0;
    while (((c_cnt / S) % 4) != 1 && guard_cnt < 16) begin
      run(1);
      guard_cnt++;
    end
    d3 = 4'd7;
    run(36);

    d2 = 4'hC;
    run(36);

    // Blink the right pair, then the left pair, then leave adjust mode.
    adj = 1'b1; sel = 1'b1;
    run(70);
    sel = 1'b0;
    run(24);
    adj = 1'b0;
    run(20);

    d1 = 4'd0; d2 = 4'd0; d3 = 4'd5; d4 = 4'd0;
    run(40);

    // Reset in the middle of slot 2.
    guard_cnt = 0;
    while (!(((c_cnt / S) % 4) == 2 && (c_cnt % S) == 2) && guard_cnt < 16) begin
      run(1);
      guard_cnt++;
    end
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(24);

    // Randomised digits, adjust/select and rare resets.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        d1 = 4'($urandom_range(0, 15));
        d2 = 4'($urandom_range(0, 15));
        d3 = 4'($urandom_range(0, 15));
        d4 = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 15) == 0) d1 = 4'd0;
      if ($urandom_range(0, 39) == 0) adj = ~adj;
      if ($urandom_range(0, 29) == 0) sel = ~sel;
      rst = ($urandom_range(0, 199) == 0);
      run(1);
    end
    rst = 1'b0;
    run(4);

    @(negedge clk_used);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected outputs left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Downstream consumer of the 4-digit BCD stopwatch/alarm counter.
- Time-multiplexes digit1..digit4 onto a 4-digit common-anode seven-segment display.
- Provides per-digit anti-ghost guard and adjust-mode blinking.
- Captures digits once per frame into a shadow register so a frame never mixes two counter values.

Parameters:
- SCAN_DIV, 100000: clk_used cycles each digit is selected (1 kHz digit rate at 100 MHz).
- GUARD, 2: cycles at the start of each digit slot with all anodes off (anti-ghost); must be < SCAN_DIV.
- BLINK_DIV, 25000000: clk_used cycles per blink half-period.
- DP_POS, 1: digit index (0..3) whose decimal point is lit; 4 = no decimal point.

Ports:
- clk_used  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- digit1  in  4  BCD, leftmost digit
- digit2  in  4  BCD
- digit3  in  4  BCD
- digit4  in  4  BCD, rightmost digit
- adj  in  1  adjust mode; enables blinking
- sel  in  1  blink select: 0 = digit1/digit2 pair, 1 = digit3/digit4 pair
- an  out  4  anode enables, active-low; an[3] = digit1 … an[0] = digit4
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low

Behaviour:
- Reset values: an=4'b1111, seg=7'b1111111, dp=1. Internal state: scan_cnt=0, idx=0, shadow digits all 0, blink_cnt=0, blink_phase=0.
- scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - tick = (scan_cnt==SCAN_DIV-1).
  - On tick, idx advances 0→1→2→3→0.
- Frame capture: on the tick where idx==3, shadow ← {digit1..digit4}, sampled that cycle. The frame starting at idx=0 uses those values.
  - Until the first capture after reset, shadow shows 0000.
- Outputs are registered, one cycle latency from internal state (idx, scan_cnt, shadow, blink_phase).
- Anode selection for slot idx:
  - idx 0 → an=0111
  - idx 1 → an=1011
  - idx 2 → an=1101
  - idx 3 → an=1110
- Guard: while scan_cnt < GUARD, an=1111 and seg=1111111.
- Decode: shadow value 0–9 gives standard patterns (e.g. 0→1000000, 1→1111001, 8→0000000).
  - Values 10–15 give a dash (0111111).
- dp=0 when idx==DP_POS and not in guard; otherwise 1.
- Blink:
  - adj=0: blink_cnt held at 0, blink_phase held at 0.
  - adj=1: blink_cnt counts 0..BLINK_DIV-1; at wrap, blink_phase toggles.
  - When adj=1 and blink_phase=1, anodes of the selected pair are forced high (sel=0 → idx 0,1; sel=1 → idx 2,3). The other pair is unaffected.
  - On entering adj, the first half-period is visible.
- sel change mid-blink takes effect on the next output register update; the blink counter is not reset.
- rst mid-frame returns all state to reset values on that edge. Outputs are blanked the following cycle.
- Inputs are not synchronised; the upstream counter shares clk_used.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: within a captured frame, leading shadow digits equal to 0 (scanning from digit1 through digit3) have seg=1111111. Digit4 is always shown. The blank mask is computed at capture time and held for the frame. dp is still driven.
- Undefined: all four digits are always decoded.

Decomposition:
- Package seg7_pkg:
  - SEG_DIGIT[0:9] pattern constants
  - SEG_DASH, SEG_BLANK, AN_OFF constants
  - typedef for the 2-bit digit index
- Sub-module bcd_to_seg7: combinational 4-bit → 7-bit decoder, dash for >9. Instantiated once on the muxed shadow digit.

Test Plan (bench params SCAN_DIV=4, GUARD=1, BLINK_DIV=8, DP_POS=1):
- Reset → an=1111, seg=1111111, dp=1 at the first edge after rst; rst low → first frame shows 0000. Each slot: 1 cycle blank, then 3 cycles of the anode pattern.
- Digits 1,2,3,4 held → second frame shows seg 1111001/0100100/0110000/0011001 on an 0111/1011/1101/1110; dp=0 only in the an=1011 slots.
- digit3 changed 3→7 mid-frame (idx=1) → current frame still shows 3; next frame shows 7 (1111000). No mixed frame.
- digit2=4'hC → dash 0111111 in slot 1.
- adj=1, sel=1 → slots 2,3 show an=1111 on alternating 8-cycle half-periods (first half visible); slots 0,1 unaffected. adj=0 → all digits steady immediately.
- LEADING_ZERO_BLANK_EN defined, digits 0,0,5,0 → slots 0,1 seg=1111111; slot 2 shows 5; slot 3 shows 0 (1000000).
